// File: rtl/naneye_frame_ctrl.sv
// Line/frame sequencer between the NanEye pixel deserializer and the output
// register stage. It counts pixels per line and lines per frame, checks them
// against the configured geometry, and produces registered pixel data with a
// load strobe, H/V sync windows, a frame counter and sticky error flags.
// A malformed frame is dropped, and the block resynchronises on the next
// FRAME_SYNC.

module naneye_frame_ctrl #(
    parameter int D_WIDTH = 10,
    parameter int COLS    = 250,
    parameter int ROWS    = 250,
    parameter int COL_W   = 8,
    parameter int ROW_W   = 8
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               ENABLE,
    input  logic [D_WIDTH-1:0] PAR_IN,
    input  logic               PAR_EN,
    input  logic               LINE_END,
    input  logic               FRAME_SYNC,
    input  logic               ERR_CLR,
    output logic [D_WIDTH-1:0] PAR_OUT,
    output logic               PIX_LOAD,
    output logic               H_SYNC,
    output logic               V_SYNC,
    output logic               FRAME_DONE,
    output logic [15:0]        FRAME_CNT,
    output logic               LINE_ERR,
    output logic               FRAME_ERR
);

    localparam logic [COL_W-1:0] COLS_C = COL_W'(COLS);
    localparam logic [ROW_W-1:0] ROWS_C = ROW_W'(ROWS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_FS = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [COL_W-1:0]     pix_cnt_q, pix_cnt_d;
    logic [ROW_W-1:0]     row_cnt_q, row_cnt_d;
    logic                 ovf_q, ovf_d;
    logic [D_WIDTH-1:0]   par_out_q, par_out_d;
    logic                 pix_load_q, pix_load_d;
    logic                 h_sync_q, h_sync_d;
    logic                 v_sync_q, v_sync_d;
    logic                 frame_done_q, frame_done_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 line_err_q, line_err_d;
    logic                 frame_err_q, frame_err_d;

    // Line-evaluation helpers: the pixel count and overflow flag as they stand
    // after the current cycle's pixel, so a pixel coincident with LINE_END is
    // counted before the line is judged.
    logic [COL_W-1:0]     pix_next;
    logic                 ovf_next;
    logic [ROW_W-1:0]     row_inc;
    logic                 line_err_set;
    logic                 frame_err_set;

    // Next-state and registered-output logic for the sequencer.
    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        row_cnt_d     = row_cnt_q;
        ovf_d         = ovf_q;
        par_out_d     = par_out_q;
        pix_load_d    = 1'b0;
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        frame_done_d  = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        pix_next      = pix_cnt_q;
        ovf_next      = ovf_q;
        row_inc       = row_cnt_q + ROW_W'(1);
        line_err_set  = 1'b0;
        frame_err_set = 1'b0;

        if (!ENABLE) begin
            state_d   = IDLE;
            pix_cnt_d = '0;
            row_cnt_d = '0;
            ovf_d     = 1'b0;
            h_sync_d  = 1'b0;
            v_sync_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = WAIT_FS;
                    pix_cnt_d = '0;
                    row_cnt_d = '0;
                    ovf_d     = 1'b0;
                    h_sync_d  = 1'b0;
                    v_sync_d  = 1'b0;
                end

                WAIT_FS: begin
                    if (FRAME_SYNC) begin
                        state_d   = ACTIVE;
                        pix_cnt_d = '0;
                        row_cnt_d = '0;
                        ovf_d     = 1'b0;
                        h_sync_d  = 1'b0;
                        v_sync_d  = 1'b1;
                    end
                end

                ACTIVE: begin
                    if (FRAME_SYNC) begin
                        // A sync after any progress means the previous frame was cut short.
                        if ((row_cnt_q != '0) || (pix_cnt_q != '0)) begin
                            frame_err_set = 1'b1;
                        end
                        pix_cnt_d = '0;
                        row_cnt_d = '0;
                        ovf_d     = 1'b0;
                        h_sync_d  = 1'b0;
                        v_sync_d  = 1'b1;
                    end else begin
                        if (PAR_EN) begin
                            if (pix_cnt_q < COLS_C) begin
                                par_out_d  = PAR_IN;
                                pix_load_d = 1'b1;
                                pix_next   = pix_cnt_q + COL_W'(1);
                                if (pix_cnt_q == '0) begin
                                    h_sync_d = 1'b1;
                                end
                            end else begin
                                ovf_next = 1'b1;
                            end
                        end
                        pix_cnt_d = pix_next;
                        ovf_d     = ovf_next;

                        if (LINE_END) begin
                            h_sync_d  = 1'b0;
                            pix_cnt_d = '0;
                            ovf_d     = 1'b0;
                            if ((pix_next != COLS_C) || ovf_next) begin
                                line_err_set = 1'b1;
                                v_sync_d     = 1'b0;
                                row_cnt_d    = '0;
                                state_d      = WAIT_FS;
                            end else if (row_inc == ROWS_C) begin
                                frame_done_d = 1'b1;
                                frame_cnt_d  = frame_cnt_q + 16'd1;
                                v_sync_d     = 1'b0;
                                row_cnt_d    = '0;
                                state_d      = WAIT_FS;
                            end else begin
                                row_cnt_d = row_inc;
                            end
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Sticky flags: a clear request loses to an error raised in the same cycle.
        line_err_d  = (line_err_q  & ~ERR_CLR) | line_err_set;
        frame_err_d = (frame_err_q & ~ERR_CLR) | frame_err_set;
    end

    // State and output registers, all cleared asynchronously by RESET.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            pix_cnt_q    <= '0;
            row_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            par_out_q    <= '0;
            pix_load_q   <= 1'b0;
            h_sync_q     <= 1'b0;
            v_sync_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            row_cnt_q    <= row_cnt_d;
            ovf_q        <= ovf_d;
            par_out_q    <= par_out_d;
            pix_load_q   <= pix_load_d;
            h_sync_q     <= h_sync_d;
            v_sync_q     <= v_sync_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign PAR_OUT    = par_out_q;
    assign PIX_LOAD   = pix_load_q;
    assign H_SYNC     = h_sync_q;
    assign V_SYNC     = v_sync_q;
    assign FRAME_DONE = frame_done_q;
    assign FRAME_CNT  = frame_cnt_q;
    assign LINE_ERR   = line_err_q;
    assign FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_naneye_frame_ctrl.sv
// Testbench for naneye_frame_ctrl with a 4x3 sensor geometry. A frame-level
// reference model tracks which pixels must appear on PAR_OUT, how many frames
// complete and the expected sticky error flags.

module tb_naneye_frame_ctrl;

    localparam int D_WIDTH = 10;
    localparam int COLS    = 4;
    localparam int ROWS    = 3;
    localparam int COL_W   = 3;
    localparam int ROW_W   = 2;

    logic               CLOCK = 1'b0;
    logic               RESET;
    logic               ENABLE;
    logic [D_WIDTH-1:0] PAR_IN;
    logic               PAR_EN;
    logic               LINE_END;
    logic               FRAME_SYNC;
    logic               ERR_CLR;
    logic [D_WIDTH-1:0] PAR_OUT;
    logic               PIX_LOAD;
    logic               H_SYNC;
    logic               V_SYNC;
    logic               FRAME_DONE;
    logic [15:0]        FRAME_CNT;
    logic               LINE_ERR;
    logic               FRAME_ERR;

    naneye_frame_ctrl #(
        .D_WIDTH (D_WIDTH),
        .COLS    (COLS),
        .ROWS    (ROWS),
        .COL_W   (COL_W),
        .ROW_W   (ROW_W)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .ENABLE     (ENABLE),
        .PAR_IN     (PAR_IN),
        .PAR_EN     (PAR_EN),
        .LINE_END   (LINE_END),
        .FRAME_SYNC (FRAME_SYNC),
        .ERR_CLR    (ERR_CLR),
        .PAR_OUT    (PAR_OUT),
        .PIX_LOAD   (PIX_LOAD),
        .H_SYNC     (H_SYNC),
        .V_SYNC     (V_SYNC),
        .FRAME_DONE (FRAME_DONE),
        .FRAME_CNT  (FRAME_CNT),
        .LINE_ERR   (LINE_ERR),
        .FRAME_ERR  (FRAME_ERR)
    );

    always #5 CLOCK = ~CLOCK;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state: pixels still owed on PAR_OUT, and frame progress.
    logic [D_WIDTH-1:0] expQ[$];
    bit                 frameAlive  = 1'b0;
    int                 linesDone   = 0;
    int                 pixInLine   = 0;
    logic [15:0]        expFrames   = 16'd0;
    int                 expDone     = 0;
    logic               expLineErr  = 1'b0;
    logic               expFrameErr = 1'b0;

    // Observed event counters maintained by the monitor.
    int   loadCount = 0;
    int   doneCount = 0;
    int   hRise     = 0;
    logic hPrev     = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Monitor: every PIX_LOAD must deliver the next pixel the model expects.
    always @(negedge CLOCK) begin
        if (PIX_LOAD) begin
            loadCount++;
            if (expQ.size() == 0) begin
                checkOutput("spuriousLoad", 32'(PIX_LOAD), 32'd0);
            end else begin
                checkOutput("parOut", 32'(PAR_OUT), 32'(expQ.pop_front()));
            end
        end
        if (FRAME_DONE) begin
            doneCount++;
        end
        if (H_SYNC && !hPrev) begin
            hRise++;
        end
        hPrev = H_SYNC;
    end

    // Drives one cycle of inputs, waits for the resulting outputs, then idles the pulses.
    task automatic applyStimulus(input logic pe, input logic [D_WIDTH-1:0] d,
                                 input logic le, input logic fs, input logic clr);
        PAR_EN     = pe;
        PAR_IN     = d;
        LINE_END   = le;
        FRAME_SYNC = fs;
        ERR_CLR    = clr;
        @(negedge CLOCK);
        #1;
        PAR_EN     = 1'b0;
        LINE_END   = 1'b0;
        FRAME_SYNC = 1'b0;
        ERR_CLR    = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic modelClear(input logic clr);
        if (clr) begin
            expLineErr  = 1'b0;
            expFrameErr = 1'b0;
        end
    endtask

    task automatic modelPixel(input logic [D_WIDTH-1:0] d);
        if (frameAlive) begin
            if (pixInLine < COLS) expQ.push_back(d);
            pixInLine++;
        end
    endtask

    // FRAME_SYNC issued while the sequencer waits for a frame.
    task automatic startFrame(input logic clr);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, clr);
        modelClear(clr);
        frameAlive = 1'b1;
        linesDone  = 0;
        pixInLine  = 0;
    endtask

    // FRAME_SYNC issued inside a frame, together with a pixel that must be ignored.
    task automatic midSync(input logic clr);
        logic [D_WIDTH-1:0] d;
        d = D_WIDTH'($urandom);
        applyStimulus(1'b1, d, 1'b0, 1'b1, clr);
        modelClear(clr);
        if (frameAlive && (linesDone > 0 || pixInLine > 0)) expFrameErr = 1'b1;
        frameAlive = 1'b1;
        linesDone  = 0;
        pixInLine  = 0;
    endtask

    task automatic drivePixel(input logic [D_WIDTH-1:0] d);
        modelPixel(d);
        applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drivePixels(input int n, input int gapMax);
        for (int k = 0; k < n; k++) begin
            drivePixel(D_WIDTH'($urandom));
            if (gapMax > 0) idleCycles($urandom_range(0, gapMax));
        end
    endtask

    // LINE_END, optionally carrying the line's last pixel, judged by the model.
    task automatic endLine(input bit withPixel, input logic clr);
        logic [D_WIDTH-1:0] d;
        d = D_WIDTH'($urandom);
        if (withPixel) modelPixel(d);
        applyStimulus(withPixel, d, 1'b1, 1'b0, clr);
        modelClear(clr);
        if (frameAlive) begin
            if (pixInLine != COLS) begin
                frameAlive = 1'b0;
                expLineErr = 1'b1;
            end else begin
                linesDone++;
                if (linesDone == ROWS) begin
                    expFrames++;
                    expDone++;
                    frameAlive = 1'b0;
                end
            end
            pixInLine = 0;
        end
    endtask

    task automatic driveLine(input int n, input bit coinc, input int gapMax, input logic clr);
        if (coinc && n > 0) begin
            drivePixels(n - 1, gapMax);
            endLine(1'b1, clr);
        end else begin
            drivePixels(n, gapMax);
            endLine(1'b0, clr);
        end
    endtask

    task automatic checkFrame(input string tag);
        checkOutput({tag, "/frameCnt"},  32'(FRAME_CNT),  32'(expFrames));
        checkOutput({tag, "/lineErr"},   32'(LINE_ERR),   32'(expLineErr));
        checkOutput({tag, "/frameErr"},  32'(FRAME_ERR),  32'(expFrameErr));
        checkOutput({tag, "/doneCount"}, 32'(doneCount),  32'(expDone));
        checkOutput({tag, "/pending"},   32'(expQ.size()), 32'd0);
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        int h0;
        int l0;
        int n;

        RESET      = 1'b1;
        ENABLE     = 1'b0;
        PAR_IN     = '0;
        PAR_EN     = 1'b0;
        LINE_END   = 1'b0;
        FRAME_SYNC = 1'b0;
        ERR_CLR    = 1'b0;
        @(negedge CLOCK);
        @(negedge CLOCK);
        #1;

        checkOutput("rst/parOut",    32'(PAR_OUT),    32'd0);
        checkOutput("rst/pixLoad",   32'(PIX_LOAD),   32'd0);
        checkOutput("rst/hSync",     32'(H_SYNC),     32'd0);
        checkOutput("rst/vSync",     32'(V_SYNC),     32'd0);
        checkOutput("rst/frameDone", 32'(FRAME_DONE), 32'd0);
        checkOutput("rst/frameCnt",  32'(FRAME_CNT),  32'd0);
        checkOutput("rst/errs",      32'({LINE_ERR, FRAME_ERR}), 32'd0);

        RESET  = 1'b0;
        ENABLE = 1'b1;
        idleCycles(1);

        // Nominal frame with data 1..12, LINE_END on its own cycle.
        h0 = hRise;
        startFrame(1'b0);
        checkOutput("nom/vSyncUp", 32'(V_SYNC), 32'd1);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) drivePixel(D_WIDTH'(r * COLS + c + 1));
            endLine(1'b0, 1'b0);
        end
        checkOutput("nom/hRises", 32'(hRise - h0), 32'(ROWS));
        checkOutput("nom/vSyncDown", 32'(V_SYNC), 32'd0);
        checkFrame("nom");

        // Short line on the second row drops the frame; later lines are ignored.
        startFrame(1'b0);
        driveLine(COLS, 1'b0, 0, 1'b0);
        driveLine(COLS - 1, 1'b0, 0, 1'b0);
        checkOutput("short/vSync", 32'(V_SYNC), 32'd0);
        l0 = loadCount;
        driveLine(COLS, 1'b0, 0, 1'b0);
        checkOutput("short/ignored", 32'(loadCount - l0), 32'd0);
        checkFrame("short");
        startFrame(1'b1);
        for (int r = 0; r < ROWS; r++) driveLine(COLS, 1'b0, 0, 1'b0);
        checkFrame("afterShort");

        // Long line: only COLS pixels are loaded and the line is flagged.
        startFrame(1'b0);
        l0 = loadCount;
        driveLine(COLS + 1, 1'b0, 0, 1'b0);
        checkOutput("long/loads", 32'(loadCount - l0), 32'(COLS));
        checkFrame("long");

        // ERR_CLR together with a new line error keeps LINE_ERR set.
        startFrame(1'b0);
        driveLine(COLS - 1, 1'b0, 0, 1'b1);
        checkOutput("clrVsErr/lineErr", 32'(LINE_ERR), 32'(expLineErr));
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        modelClear(1'b1);
        checkFrame("clrAlone");

        // Every line ends with the last pixel coincident with LINE_END.
        startFrame(1'b0);
        for (int r = 0; r < ROWS; r++) driveLine(COLS, 1'b1, 0, 1'b0);
        checkFrame("coinc");

        // Mid-frame FRAME_SYNC after one line plus two pixels, then a full frame.
        startFrame(1'b0);
        driveLine(COLS, 1'b0, 0, 1'b0);
        drivePixels(2, 0);
        midSync(1'b0);
        checkOutput("mid/frameErr", 32'(FRAME_ERR), 32'd1);
        checkOutput("mid/vSync", 32'(V_SYNC), 32'd1);
        for (int r = 0; r < ROWS; r++) driveLine(COLS, 1'b0, 0, 1'b0);
        checkFrame("mid");
        startFrame(1'b1);
        drivePixels(1, 0);
        midSync(1'b1);
        checkOutput("midClr/frameErr", 32'(FRAME_ERR), 32'(expFrameErr));
        for (int r = 0; r < ROWS; r++) driveLine(COLS, 1'b0, 0, 1'b0);
        checkFrame("midClr");

        // Randomized frames: mostly valid lines, some short or long, random gaps.
        for (int f = 0; f < 40; f++) begin
            startFrame(logic'($urandom_range(0, 4) == 0));
            for (int r = 0; r < ROWS; r++) begin
                n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 6)) : COLS;
                driveLine(n, bit'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);
            end
            idleCycles($urandom_range(0, 2));
            checkFrame("rand");
        end

        // FRAME_CNT wraps from 0xFFFF to 0 on the next valid frame.
        force dut.frame_cnt_q = 16'hFFFF;
        idleCycles(1);
        release dut.frame_cnt_q;
        idleCycles(1);
        expFrames = 16'hFFFF;
        checkOutput("wrap/preload", 32'(FRAME_CNT), 32'h0000FFFF);
        startFrame(1'b0);
        for (int r = 0; r < ROWS; r++) driveLine(COLS, 1'b0, 0, 1'b0);
        checkFrame("wrap");

        // ENABLE dropped mid-line closes both windows and holds the counters.
        startFrame(1'b0);
        drivePixels(2, 0);
        checkOutput("en/hSyncUp", 32'(H_SYNC), 32'd1);
        ENABLE = 1'b0;
        idleCycles(1);
        frameAlive = 1'b0;
        expQ.delete();
        checkOutput("en/hSync",    32'(H_SYNC),    32'd0);
        checkOutput("en/vSync",    32'(V_SYNC),    32'd0);
        checkOutput("en/frameCnt", 32'(FRAME_CNT), 32'(expFrames));
        checkOutput("en/lineErr",  32'(LINE_ERR),  32'(expLineErr));
        ENABLE = 1'b1;
        idleCycles(1);

        // Asynchronous reset mid-frame clears every output before the next edge.
        applyStimulus(1'b1, 10'h155, 1'b1, 1'b0, 1'b0);
        startFrame(1'b0);
        drivePixels(2, 0);
        checkOutput("rstMid/vSyncUp", 32'(V_SYNC), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        checkOutput("rstMid/parOut",    32'(PAR_OUT),    32'd0);
        checkOutput("rstMid/pixLoad",   32'(PIX_LOAD),   32'd0);
        checkOutput("rstMid/hSync",     32'(H_SYNC),     32'd0);
        checkOutput("rstMid/vSync",     32'(V_SYNC),     32'd0);
        checkOutput("rstMid/frameCnt",  32'(FRAME_CNT),  32'd0);
        checkOutput("rstMid/errs",      32'({LINE_ERR, FRAME_ERR}), 32'd0);
        frameAlive = 1'b0;
        expQ.delete();
        @(negedge CLOCK);
        #1;
        RESET = 1'b0;
        idleCycles(2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
